// File: rtl/coeff_sample_streamer.sv
// coeff_sample_streamer
//   Sample source for the coefficient calculator. Holds one x/y dataset in
//   on-chip memory, launches a regression run, streams sample pairs as the
//   calculator consumes them, flags the final sample with cout and captures
//   the resulting b0/b1 coefficients when the calculator reports completion.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous reset, active-low
//   wr_en         in   dataset write strobe (IDLE only)
//   wr_addr       in   write index; indices >= DEPTH are dropped
//   wr_x, wr_y    in   sample pair to store
//   start         in   begin a run (IDLE only)
//   busy          out  high in every state except IDLE
//   x_bus, y_bus  out  current sample pair presented to the calculator
//   en            out  one-cycle calculator enable pulse
//   cout          out  current index is the last sample of the dataset
//   coeff_ready   in   calculator consumes the current pair this cycle
//   coeff_done    in   calculator finished; b0_in/b1_in valid this cycle
//   b0_in, b1_in  in   calculator coefficients
//   b0, b1        out  captured coefficients
//   result_valid  out  b0/b1 hold the results of the last completed run
module coeff_sample_streamer #(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 150,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_x,
  input  logic [DATA_W-1:0] wr_y,
  input  logic              start,
  output logic              busy,
  output logic [DATA_W-1:0] x_bus,
  output logic [DATA_W-1:0] y_bus,
  output logic              en,
  output logic              cout,
  input  logic              coeff_ready,
  input  logic              coeff_done,
  input  logic [DATA_W-1:0] b0_in,
  input  logic [DATA_W-1:0] b1_in,
  output logic [DATA_W-1:0] b0,
  output logic [DATA_W-1:0] b1,
  output logic              result_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENABLE,
    S_PRIME,
    S_STREAM,
    S_DRAIN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_t            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] idx_d;
  logic [DATA_W-1:0] x_q;
  logic [DATA_W-1:0] y_q;
  logic [DATA_W-1:0] b0_q;
  logic [DATA_W-1:0] b1_q;
  logic              rv_q;

  logic [DATA_W-1:0] mem_x [DEPTH];
  logic [DATA_W-1:0] mem_y [DEPTH];

  logic at_last;
  logic wr_ok;

  // The index wraps at DEPTH rather than at 2**ADDR_W, so the successor of
  // the last sample is index 0 and the buses reload mem[0] on that edge.
  assign at_last = (idx_q == LAST_IDX);
  assign idx_d   = at_last ? '0 : idx_q + 1'b1;

  // Dataset is frozen while a run is in progress; out-of-range indices are dropped.
  assign wr_ok = (state_q == S_IDLE) && wr_en && ({1'b0, wr_addr} < DEPTH_EXT);

  // ---- dataset memory (contents survive reset) ----
  always_ff @(posedge clk) begin
    if (rst && wr_ok) begin
      mem_x[wr_addr] <= wr_x;
      mem_y[wr_addr] <= wr_y;
    end
  end

  // ---- run control FSM ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      rv_q    <= 1'b0;
    end else if ((state_q != S_IDLE) && coeff_done) begin
      // Completion is accepted in any active state and outranks coeff_ready.
      b0_q    <= b0_in;
      b1_q    <= b1_in;
      rv_q    <= 1'b1;
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_ENABLE;
            idx_q   <= '0;
            rv_q    <= 1'b0;
          end
        end
        S_ENABLE: begin
          state_q <= S_PRIME;
        end
        S_PRIME: begin
          x_q     <= mem_x[0];
          y_q     <= mem_y[0];
          state_q <= S_STREAM;
        end
        S_STREAM: begin
          // Next pair is fetched on the consuming edge, so there is no bubble.
          if (coeff_ready) begin
            idx_q <= idx_d;
            x_q   <= mem_x[idx_d];
            y_q   <= mem_y[idx_d];
            if (at_last) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          state_q <= S_DRAIN;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign en           = (state_q == S_ENABLE);
  assign cout         = busy && at_last;
  assign x_bus        = x_q;
  assign y_bus        = y_q;
  assign b0           = b0_q;
  assign b1           = b1_q;
  assign result_valid = rv_q;

endmodule

// File: tb/tb_coeff_sample_streamer.sv
module tb_coeff_sample_streamer;

  localparam int DATA_W = 20;
  localparam int DEPTH  = 150;
  localparam int ADDR_W = 8;
  localparam int EW     = 2 * DATA_W + 1;

  logic              clk;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_x;
  logic [DATA_W-1:0] wr_y;
  logic              start;
  logic              busy;
  logic [DATA_W-1:0] x_bus;
  logic [DATA_W-1:0] y_bus;
  logic              en;
  logic              cout;
  logic              coeff_ready;
  logic              coeff_done;
  logic [DATA_W-1:0] b0_in;
  logic [DATA_W-1:0] b1_in;
  logic [DATA_W-1:0] b0;
  logic [DATA_W-1:0] b1;
  logic              result_valid;

  coeff_sample_streamer #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .start       (start),
    .busy        (busy),
    .x_bus       (x_bus),
    .y_bus       (y_bus),
    .en          (en),
    .cout        (cout),
    .coeff_ready (coeff_ready),
    .coeff_done  (coeff_done),
    .b0_in       (b0_in),
    .b1_in       (b1_in),
    .b0          (b0),
    .b1          (b1),
    .result_valid(result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] mx [DEPTH];
  logic [DATA_W-1:0] my [DEPTH];
  logic [EW-1:0]     sb [$];
  logic [EW-1:0]     e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pair_now();
    return 64'({x_bus, y_bus, cout});
  endfunction

  task automatic sb_fill();
    sb.delete();
    for (int i = 0; i < DEPTH; i++) begin
      sb.push_back({mx[i], my[i], (i == DEPTH - 1)});
    end
  endtask

  task automatic mem_write(input int a, input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(a);
    wr_x    = x;
    wr_y    = y;
    mx[a]   = x;
    my[a]   = y;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Issues start from IDLE and walks ENABLE and PRIME, ending at the first STREAM cycle.
  task automatic start_run(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    chk({tag, "_en_pulse"}, 64'(en), 64'(1));
    chk({tag, "_busy"}, 64'(busy), 64'(1));
    chk({tag, "_rv_clr"}, 64'(result_valid), 64'(0));
    @(negedge clk);
    chk({tag, "_en_low"}, 64'(en), 64'(0));
    @(negedge clk);
  endtask

  task automatic stream_ready(input string tag, input int n);
    coeff_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      e = sb.pop_front();
      chk(tag, pair_now(), 64'(e));
      @(negedge clk);
    end
    coeff_ready = 1'b0;
  endtask

  task automatic finish_done(input string tag, input logic [DATA_W-1:0] c0, input logic [DATA_W-1:0] c1);
    coeff_done = 1'b1;
    b0_in      = c0;
    b1_in      = c1;
    @(negedge clk);
    coeff_done = 1'b0;
    chk({tag, "_b0"}, 64'(b0), 64'(c0));
    chk({tag, "_b1"}, 64'(b1), 64'(c1));
    chk({tag, "_rv"}, 64'(result_valid), 64'(1));
    chk({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_x = '0; wr_y = '0;
    start = 1'b0; coeff_ready = 1'b0; coeff_done = 1'b0; b0_in = '0; b1_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({x_bus, y_bus, b0, b1}), 64'(0));
    chk("reset_ctrl", 64'({en, busy, result_valid, cout}), 64'(0));
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < DEPTH; i++) begin
      mem_write(i, DATA_W'(i), DATA_W'(2 * i + 1));
    end

    // Run 1: ready held high, full walk then DRAIN
    start_run("t1");
    sb_fill();
    stream_ready("t1_pair", DEPTH);
    for (int k = 0; k < 2; k++) begin
      chk("t1_drain_busy", 64'(busy), 64'(1));
      chk("t1_drain_pair", pair_now(), 64'({mx[0], my[0], 1'b0}));
      @(negedge clk);
    end
    finish_done("t3", 20'h00123, 20'h00456);

    // Run 2: ready toggling, each pair held across a stalled cycle
    start_run("t2");
    sb_fill();
    for (int k = 0; k < 2 * DEPTH; k++) begin
      if (k % 2 == 0) begin
        coeff_ready = 1'b0;
        chk("t2_hold", pair_now(), 64'(sb[0]));
      end else begin
        coeff_ready = 1'b1;
        e = sb.pop_front();
        chk("t2_adv", pair_now(), 64'(e));
      end
      @(negedge clk);
    end
    coeff_ready = 1'b0;
    chk("t2_all_consumed", 64'(sb.size()), 64'(0));
    chk("t2_drain_pair", pair_now(), 64'({mx[0], my[0], 1'b0}));
    chk("t2_drain_busy", 64'(busy), 64'(1));
    finish_done("t2_done", 20'hFEDCB, 20'h0BA98);

    // Run 4: early done at index 40 with ready in the same cycle
    start_run("t4");
    sb_fill();
    stream_ready("t4_pair", 40);
    chk("t4_at40", pair_now(), 64'(sb[0]));
    coeff_ready = 1'b1;
    finish_done("t4_done", 20'h0A0A0, 20'h0B0B0);
    coeff_ready = 1'b0;
    chk("t4_no_advance", 64'(x_bus), 64'(mx[40]));
    chk("t4_cout_idle", 64'({cout, en}), 64'(0));
    @(negedge clk);
    chk("t4_stay_idle", 64'(busy), 64'(0));

    // Run 5: reset at index 75
    start_run("t5");
    sb_fill();
    stream_ready("t5_pair", 75);
    chk("t5_at75", pair_now(), 64'(sb[0]));
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("t5_rst_data", 64'({x_bus, y_bus, b0, b1}), 64'(0));
    chk("t5_rst_ctrl", 64'({en, busy, result_valid, cout}), 64'(0));

    // Restart from index 0; start and a write during STREAM must be ignored
    start_run("t5r");
    sb_fill();
    chk("t5r_idx0", pair_now(), 64'(sb[0]));
    start   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(3);
    wr_x    = 20'hABCDE;
    wr_y    = 20'h12345;
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    chk("t6_no_restart", 64'({busy, en}), 64'({1'b1, 1'b0}));
    chk("t6_hold", pair_now(), 64'(sb[0]));
    stream_ready("t6_pair", 10);
    finish_done("t6_done", 20'h11111, 20'h22222);

    // Run 7: write and start in the same IDLE cycle; written pair is used
    wr_en   = 1'b1;
    wr_addr = '0;
    wr_x    = 20'h55555;
    wr_y    = 20'h2AAAA;
    mx[0]   = 20'h55555;
    my[0]   = 20'h2AAAA;
    start_run("t7");
    sb_fill();
    chk("t7_mem3_intact", 64'({mx[3], my[3]}), 64'({20'd3, 20'd7}));
    stream_ready("t7_pair", 5);
    finish_done("t7_done", 20'h33333, 20'h44444);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
